// File: rtl/thread_sched_state_if.sv
// Scheduler <-> front-end signal bundle for thread_sched_state.
// master = scheduler side, slave = pipeline/thread-state side.
interface thread_sched_state_if #(
    parameter int N_THREADS_MSB    = 3,
    parameter int THREAD_STATE_MSB = 1,
    parameter int N_STAGES         = 4
);
    logic                        entry_pt_switch;
    logic [N_THREADS_MSB:0]      ts_rd_num;
    logic [THREAD_STATE_MSB:0]   ts_rd;
    logic                        NEXT_THREAD;
    logic                        INVALIDATE;
    logic                        INSTR_WAIT;
    logic                        RELOAD;
    logic [N_THREADS_MSB:0]      thread_num;
    logic [N_THREADS_MSB:0]      thread_num_ahead;
    logic                        thread_init;
    logic                        thread_almost_switched;
    logic [N_STAGES-1:0]         stage_allow;
    logic                        err;

    modport master (
        input  entry_pt_switch, ts_rd, NEXT_THREAD, INVALIDATE, INSTR_WAIT,
        output ts_rd_num, RELOAD, thread_num, thread_num_ahead, thread_init,
               thread_almost_switched, stage_allow, err
    );

    modport slave (
        output entry_pt_switch, ts_rd, NEXT_THREAD, INVALIDATE, INSTR_WAIT,
        input  ts_rd_num, RELOAD, thread_num, thread_num_ahead, thread_init,
               thread_almost_switched, stage_allow, err
    );
endinterface

// File: rtl/thread_sched_state.sv
// Thread scheduler and fetch/decode stage-enable controller (round robin, init sweep).
// Optional protocol checking is enabled by defining STATE_ERR_CHECK_EN.
module thread_sched_state #(
    parameter int                        N_CORES          = 4,
    parameter int                        N_THREADS        = 4 * N_CORES,
    parameter int                        N_THREADS_MSB    = $clog2(N_THREADS) - 1,
    parameter int                        THREAD_STATE_MSB = 1,
    parameter logic [THREAD_STATE_MSB:0] TS_RDY           = 2'b01,
    parameter int                        N_STAGES         = 4
) (
    input  logic                 CLK,
    input  logic                 RST_N,
    thread_sched_state_if.master bus
);
    localparam logic [N_THREADS_MSB:0] LAST_IDX  = (N_THREADS_MSB+1)'(N_THREADS - 1);
    localparam logic [N_THREADS_MSB:0] IDX_ONE   = (N_THREADS_MSB+1)'(1);
    localparam logic [N_STAGES-1:0]    STAGE_ONE = N_STAGES'(1);

    typedef enum logic {S_INIT, S_RUN} state_t;

    state_t                 state_reg, state_next;
    logic [N_THREADS_MSB:0] thread_num_reg, thread_num_next;
    logic [N_THREADS_MSB:0] ahead_reg, ahead_next;
    logic [N_THREADS_MSB:0] ts_rd_num_reg, ts_rd_num_next;
    logic                   ahead_valid_reg, ahead_valid_next;
    logic                   pend_reg, pend_next;
    logic [N_STAGES-1:0]    stage_reg, stage_next;
    logic [N_STAGES-1:0]    stage_fill;
    logic                   almost_reg;
    logic                   reload;

    function automatic logic [N_THREADS_MSB:0] next_idx(input logic [N_THREADS_MSB:0] i);
        return (i == LAST_IDX) ? '0 : i + IDX_ONE;
    endfunction

    // Fill pattern: each stage inherits its predecessor, stage 0 keeps itself.
    assign stage_fill[0] = stage_reg[0];
    generate
        for (genvar gi = 1; gi < N_STAGES; gi++) begin : g_fill
            assign stage_fill[gi] = stage_reg[gi-1];
        end
    endgenerate

    assign reload = (bus.NEXT_THREAD | pend_reg) & ahead_valid_reg & (state_reg != S_INIT);

    always_comb begin
        state_next       = state_reg;
        thread_num_next  = thread_num_reg;
        ahead_next       = ahead_reg;
        ts_rd_num_next   = ts_rd_num_reg;
        ahead_valid_next = ahead_valid_reg;
        pend_next        = pend_reg;

        if (bus.entry_pt_switch) begin
            state_next       = S_INIT;
            thread_num_next  = '0;
            ahead_valid_next = 1'b0;
        end else if (state_reg == S_INIT) begin
            if (thread_num_reg == LAST_IDX) begin
                state_next     = S_RUN;
                pend_next      = 1'b1;
                ts_rd_num_next = '0;
            end else begin
                thread_num_next = thread_num_reg + IDX_ONE;
            end
        end else if (reload) begin
            thread_num_next  = ahead_reg;
            ahead_valid_next = 1'b0;
            pend_next        = 1'b0;
            ts_rd_num_next   = next_idx(ahead_reg);
        end else begin
            // A yield without a candidate is remembered until the scan finds one.
            if (bus.NEXT_THREAD)
                pend_next = 1'b1;
            if (!ahead_valid_reg) begin
                if (bus.ts_rd == TS_RDY) begin
                    ahead_next       = ts_rd_num_reg;
                    ahead_valid_next = 1'b1;
                end else begin
                    ts_rd_num_next = next_idx(ts_rd_num_reg);
                end
            end
        end

        if (reload)
            stage_next = STAGE_ONE;
        else if (bus.INVALIDATE)
            stage_next = '0;
        else if (bus.INSTR_WAIT)
            stage_next = stage_reg;
        else
            stage_next = stage_fill;
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_reg       <= S_INIT;
            thread_num_reg  <= '0;
            ahead_reg       <= '0;
            ts_rd_num_reg   <= '0;
            ahead_valid_reg <= 1'b0;
            pend_reg        <= 1'b0;
            stage_reg       <= '0;
            almost_reg      <= 1'b0;
        end else begin
            state_reg       <= state_next;
            thread_num_reg  <= thread_num_next;
            ahead_reg       <= ahead_next;
            ts_rd_num_reg   <= ts_rd_num_next;
            ahead_valid_reg <= ahead_valid_next;
            pend_reg        <= pend_next;
            stage_reg       <= stage_next;
            almost_reg      <= reload;
        end
    end

`ifdef STATE_ERR_CHECK_EN
    logic err_reg;

    always_ff @(posedge CLK) begin
        if (!RST_N)
            err_reg <= 1'b0;
        else if (bus.INVALIDATE & (reload | bus.INSTR_WAIT))
            err_reg <= 1'b1;
    end

    assign bus.err = err_reg;
`else
    assign bus.err = 1'b0;
`endif

    assign bus.RELOAD                 = reload;
    assign bus.thread_num             = thread_num_reg;
    assign bus.thread_num_ahead       = ahead_reg;
    assign bus.ts_rd_num              = ts_rd_num_reg;
    assign bus.thread_init            = (state_reg == S_INIT);
    assign bus.thread_almost_switched = almost_reg;
    assign bus.stage_allow            = stage_reg;
endmodule

// File: tb/tb_thread_sched_state.sv
// Vector/scoreboard bench for thread_sched_state with 16 threads and 4 stages.
module tb_thread_sched_state;
    localparam int NT = 16;
    localparam logic [7:0] C_INIT = 8'h01, C_TNUM = 8'h02, C_REL = 8'h04, C_AHD = 8'h08,
                           C_STG  = 8'h10, C_ALM  = 8'h20, C_TS  = 8'h40, C_ERR = 8'h80;
    localparam logic [7:0] ALL = C_INIT | C_TNUM | C_REL | C_STG | C_ALM | C_TS;
`ifdef STATE_ERR_CHECK_EN
    localparam logic EXP_ERR = 1'b1;
`else
    localparam logic EXP_ERR = 1'b0;
`endif

    logic          CLK = 1'b0;
    logic          RST_N = 1'b0;
    logic [NT-1:0] rdy_mask = '1;

    always #5 CLK = ~CLK;

    thread_sched_state_if #(.N_THREADS_MSB(3), .THREAD_STATE_MSB(1), .N_STAGES(4)) bus ();

    thread_sched_state #(.N_CORES(4)) dut (
        .CLK   (CLK),
        .RST_N (RST_N),
        .bus   (bus)
    );

    assign bus.ts_rd = rdy_mask[bus.ts_rd_num] ? 2'b01 : 2'b00;

    typedef struct {
        logic        rstn, nt, inv, iw, eps;
        logic [15:0] mask;
        logic [7:0]  care;
        logic        init;
        logic [3:0]  tnum;
        logic        rel;
        logic [3:0]  ahead;
        logic [3:0]  stage;
        logic        alm;
        logic [3:0]  ts;
        logic        err;
    } vec_t;

    vec_t tbl [42];
    vec_t sb_q [$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   vec_idx  = 0;

    function automatic vec_t mk(input logic [15:0] mask, input logic nt, input logic inv,
                                input logic iw, input logic [7:0] care, input logic init,
                                input int tnum, input logic rel, input int ahead,
                                input int stage, input logic alm, input int ts);
        vec_t v;
        v.rstn = 1'b1; v.nt = nt; v.inv = inv; v.iw = iw; v.eps = 1'b0; v.mask = mask;
        v.care = care | C_ERR; v.init = init; v.tnum = 4'(tnum); v.rel = rel;
        v.ahead = 4'(ahead); v.stage = 4'(stage); v.alm = alm; v.ts = 4'(ts); v.err = 1'b0;
        return v;
    endfunction

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s vec %0d: got %0h expected %0h", name, vec_idx, act, exp);
        end
    endtask

    task automatic run_cycle(input vec_t v);
        vec_t e;
        @(negedge CLK);
        RST_N               = v.rstn;
        bus.NEXT_THREAD     = v.nt;
        bus.INVALIDATE      = v.inv;
        bus.INSTR_WAIT      = v.iw;
        bus.entry_pt_switch = v.eps;
        rdy_mask            = v.mask;
        sb_q.push_back(v);
        #1;
        e = sb_q.pop_front();
        $display("vec %0d: init=%0b tnum=%0d rel=%0b ahead=%0d stage=%b alm=%0b ts=%0d err=%0b",
                 vec_idx, bus.thread_init, bus.thread_num, bus.RELOAD, bus.thread_num_ahead,
                 bus.stage_allow, bus.thread_almost_switched, bus.ts_rd_num, bus.err);
        if (e.care & C_INIT) chk("thread_init", 8'(bus.thread_init), 8'(e.init));
        if (e.care & C_TNUM) chk("thread_num", 8'(bus.thread_num), 8'(e.tnum));
        if (e.care & C_REL)  chk("RELOAD", 8'(bus.RELOAD), 8'(e.rel));
        if (e.care & C_AHD)  chk("thread_num_ahead", 8'(bus.thread_num_ahead), 8'(e.ahead));
        if (e.care & C_STG)  chk("stage_allow", 8'(bus.stage_allow), 8'(e.stage));
        if (e.care & C_ALM)  chk("almost_switched", 8'(bus.thread_almost_switched), 8'(e.alm));
        if (e.care & C_TS)   chk("ts_rd_num", 8'(bus.ts_rd_num), 8'(e.ts));
        if (e.care & C_ERR)  chk("err", 8'(bus.err), 8'(e.err));
        vec_idx++;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v;
        bus.NEXT_THREAD = 1'b0; bus.INVALIDATE = 1'b0; bus.INSTR_WAIT = 1'b0;
        bus.entry_pt_switch = 1'b0;

        // Power-up sweep, first reload and fill, then round robin / stall / deferred switch
        for (int k = 0; k < 16; k++) tbl[k] = mk(16'hFFFF, 0, 0, 0, ALL, 1, k, 0, 0, 0, 0, 0);
        tbl[16] = mk(16'hFFFF, 0, 0, 0, ALL,         0, 15, 0, 0, 0,   0, 0);
        tbl[17] = mk(16'hFFFF, 0, 0, 0, ALL | C_AHD, 0, 15, 1, 0, 0,   0, 0);
        tbl[18] = mk(16'h0020, 0, 0, 0, ALL,         0, 0,  0, 0, 1,   1, 1);
        tbl[19] = mk(16'h0020, 0, 0, 0, ALL,         0, 0,  0, 0, 3,   0, 2);
        tbl[20] = mk(16'h0020, 0, 0, 0, ALL,         0, 0,  0, 0, 7,   0, 3);
        tbl[21] = mk(16'h0020, 0, 0, 0, ALL,         0, 0,  0, 0, 15,  0, 4);
        tbl[22] = mk(16'h0020, 0, 0, 0, ALL,         0, 0,  0, 0, 15,  0, 5);
        tbl[23] = mk(16'h0020, 0, 0, 0, ALL | C_AHD, 0, 0,  0, 5, 15,  0, 5);
        tbl[24] = mk(16'h0020, 1, 0, 0, ALL | C_AHD, 0, 0,  1, 5, 15,  0, 5);
        tbl[25] = mk(16'h0000, 0, 0, 0, ALL,         0, 5,  0, 0, 1,   1, 6);
        tbl[26] = mk(16'h0000, 0, 0, 1, ALL,         0, 5,  0, 0, 3,   0, 7);
        tbl[27] = mk(16'h0000, 0, 0, 1, ALL,         0, 5,  0, 0, 3,   0, 8);
        tbl[28] = mk(16'h0000, 0, 0, 1, ALL,         0, 5,  0, 0, 3,   0, 9);
        tbl[29] = mk(16'h0000, 0, 0, 0, ALL,         0, 5,  0, 0, 3,   0, 10);
        tbl[30] = mk(16'h0000, 0, 1, 0, ALL,         0, 5,  0, 0, 7,   0, 11);
        tbl[31] = mk(16'h0000, 1, 0, 0, ALL,         0, 5,  0, 0, 0,   0, 12);
        for (int k = 0; k < 6; k++) tbl[32+k] = mk(16'h0000, 0, 0, 0, ALL, 0, 5, 0, 0, 0, 0, (13 + k) % 16);
        tbl[38] = mk(16'h0008, 0, 0, 0, ALL,         0, 5,  0, 0, 0,   0, 3);
        tbl[39] = mk(16'h0008, 0, 0, 0, ALL | C_AHD, 0, 5,  1, 3, 0,   0, 3);
        tbl[40] = mk(16'h0008, 0, 0, 0, ALL,         0, 3,  0, 0, 1,   1, 4);
        tbl[41] = mk(16'h0008, 0, 0, 0, ALL,         0, 3,  0, 0, 3,   0, 5);

        repeat (2) @(posedge CLK);
        v = mk(16'hFFFF, 0, 0, 0, ALL, 1, 0, 0, 0, 0, 0, 0);
        v.rstn = 1'b0;
        run_cycle(v);
        for (int i = 0; i < 42; i++) run_cycle(tbl[i]);

        // entry point change restarts the sweep mid-way at thread 7
        v = mk(16'hFFFF, 0, 0, 0, 8'h00, 0, 0, 0, 0, 0, 0, 0);
        v.eps = 1'b1;
        run_cycle(v);
        for (int k = 0; k < 8; k++) begin
            v = mk(16'hFFFF, 0, 0, 0, C_INIT | C_TNUM | C_REL, 1, k, 0, 0, 0, 0, 0);
            v.eps = (k == 7);
            run_cycle(v);
        end
        for (int k = 0; k < 16; k++)
            run_cycle(mk(16'hFFFF, 0, 0, 0, C_INIT | C_TNUM | C_REL, 1, k, 0, 0, 0, 0, 0));
        run_cycle(mk(16'hFFFF, 0, 0, 0, C_INIT | C_REL | C_TS, 0, 0, 0, 0, 0, 0, 0));

        // INVALIDATE collides with RELOAD: protocol error when checking is built in
        run_cycle(mk(16'hFFFF, 0, 1, 0, C_INIT | C_REL | C_AHD, 0, 0, 1, 0, 0, 0, 0));
        v = mk(16'hFFFF, 0, 0, 0, C_TNUM | C_STG | C_ALM, 0, 0, 0, 0, 1, 1, 0);
        v.err = EXP_ERR;
        run_cycle(v);
        for (int k = 0; k < 3; k++) begin
            v = mk(16'hFFFF, 0, 0, 0, 8'h00, 0, 0, 0, 0, 0, 0, 0);
            v.err = EXP_ERR;
            run_cycle(v);
        end

        // Reset clears the sticky error and the stage pattern
        v = mk(16'hFFFF, 0, 0, 0, 8'h00, 0, 0, 0, 0, 0, 0, 0);
        v.rstn = 1'b0;
        v.err  = EXP_ERR;
        run_cycle(v);
        v = mk(16'hFFFF, 0, 0, 0, ALL, 1, 0, 0, 0, 0, 0, 0);
        v.rstn = 1'b0;
        run_cycle(v);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
